// File: rtl/knn_vote_if.sv
// ----------------------------------------------------------------------------
// knn_vote_if
//   Stream bundle for knn_vote: one candidate stream in and one result stream
//   out, both 32-bit AXI-stream style (TDATA/TVALID/TREADY).
//
//   Signals
//     Input_1_V_TDATA   candidate word {label[31:28], distance[DIST_BITS-1:0]}
//     Input_1_V_TVALID  candidate valid
//     Input_1_V_TREADY  candidate accepted when TVALID & TREADY
//     Output_1_V_TDATA  classification result word
//     Output_1_V_TVALID result valid
//     Output_1_V_TREADY downstream ready
//
//   Modports
//     slave  : the voting block (consumes candidates, produces results)
//     master : the environment (produces candidates, consumes results)
// ----------------------------------------------------------------------------
interface knn_vote_if;
    logic [31:0] Input_1_V_TDATA;
    logic        Input_1_V_TVALID;
    logic        Input_1_V_TREADY;
    logic [31:0] Output_1_V_TDATA;
    logic        Output_1_V_TVALID;
    logic        Output_1_V_TREADY;

    modport slave (
        input  Input_1_V_TDATA,
        input  Input_1_V_TVALID,
        output Input_1_V_TREADY,
        output Output_1_V_TDATA,
        output Output_1_V_TVALID,
        input  Output_1_V_TREADY
    );

    modport master (
        output Input_1_V_TDATA,
        output Input_1_V_TVALID,
        input  Input_1_V_TREADY,
        input  Output_1_V_TDATA,
        input  Output_1_V_TVALID,
        output Output_1_V_TREADY
    );
endinterface

// File: rtl/knn_vote.sv
// ----------------------------------------------------------------------------
// knn_vote
//   Majority vote over the K nearest neighbours of one test image.
//   Candidates {label, distance} stream in; the K nearest are kept in a list
//   sorted ascending by distance (single-cycle insert, earlier arrival wins on
//   equal distance). After NUM_CAND candidates the block counts votes per
//   label (K cycles), scans for the winner (K cycles) and presents one result
//   word until the downstream accepts it, then starts the next image.
//
//   Ports
//     ap_clk      clock
//     ap_rst_n    asynchronous reset, active low
//     axis        knn_vote_if.slave: candidate stream in, result stream out
//
//   Result word
//     [3:0]  winning label (4'hF when no valid label was in the list)
//     With KNN_VOTE_DIST_OUT_EN defined additionally:
//       [11:8]                 winning vote count
//       [16+DIST_BITS-1:16]    distance of the nearest neighbour
//     All other bits are 0. Both builds have identical timing.
// ----------------------------------------------------------------------------
module knn_vote #(
    parameter int K          = 3,
    parameter int NUM_CAND   = 30,
    parameter int DIST_BITS  = 8,
    parameter int NUM_LABELS = 10
) (
    input  logic      ap_clk,
    input  logic      ap_rst_n,
    knn_vote_if.slave axis
);
    localparam int CW = $clog2(K + 1);
    localparam int NW = $clog2(NUM_CAND + 1);
    localparam int IW = (K > 1) ? $clog2(K) : 1;

    localparam logic [4:0]           NL        = 5'(NUM_LABELS);
    localparam logic [IW-1:0]        LAST_IDX  = IW'(K - 1);
    localparam logic [NW-1:0]        LAST_CAND = NW'(NUM_CAND - 1);
    localparam logic [3:0]           NO_LABEL  = 4'hF;
    localparam logic [DIST_BITS-1:0] FAR       = '1;

    typedef enum logic [1:0] {
        COLLECT,
        COUNT,
        SCAN,
        EMIT
    } state_t;

    state_t               state_q, state_d;
    logic [DIST_BITS-1:0] dist_q [K];
    logic [DIST_BITS-1:0] dist_d [K];
    logic [3:0]           lbl_q  [K];
    logic [3:0]           lbl_d  [K];
    // One counter per 4-bit label code; only codes below NUM_LABELS are ever
    // incremented, the rest stay zero.
    logic [CW-1:0]        cnt_q  [16];
    logic [CW-1:0]        cnt_d  [16];
    logic [NW-1:0]        cand_cnt_q, cand_cnt_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [3:0]           win_q, win_d;
    logic [CW-1:0]        best_q, best_d;
    logic                 in_ready_q;
    logic                 out_valid_q, out_valid_d;
    logic [31:0]          out_data_q, out_data_d;

    // ------------------------------------------------------------------
    // Candidate decode and sorted insert
    // ------------------------------------------------------------------
    logic                 accept;
    logic [DIST_BITS-1:0] new_dist;
    logic [3:0]           new_lbl;
    logic [K-1:0]         closer;
    logic [DIST_BITS-1:0] ins_dist [K];
    logic [3:0]           ins_lbl  [K];
    logic                 unused_tdata_bits;

    // in_ready_q is only ever high while in COLLECT, so it alone qualifies
    // the handshake.
    assign accept   = axis.Input_1_V_TVALID & in_ready_q;
    assign new_dist = axis.Input_1_V_TDATA[DIST_BITS-1:0];
    assign new_lbl  = axis.Input_1_V_TDATA[31:28];
    assign unused_tdata_bits = ^axis.Input_1_V_TDATA[27:DIST_BITS];

    // Strict compare: an equal distance never displaces an entry, so equal
    // distances keep arrival order and an arrival equal to the last entry
    // falls off the end. Because the list is sorted, 'closer' is a
    // thermometer code; the first set bit is the insert slot and everything
    // above it shifts down by one.
    generate
        for (genvar gi = 0; gi < K; gi++) begin : g_insert
            assign closer[gi] = new_dist < dist_q[gi];
            if (gi == 0) begin : g_head
                assign ins_dist[gi] = closer[gi] ? new_dist : dist_q[gi];
                assign ins_lbl[gi]  = closer[gi] ? new_lbl  : lbl_q[gi];
            end else begin : g_body
                assign ins_dist[gi] = !closer[gi]    ? dist_q[gi]
                                    : closer[gi - 1] ? dist_q[gi - 1]
                                    :                  new_dist;
                assign ins_lbl[gi]  = !closer[gi]    ? lbl_q[gi]
                                    : closer[gi - 1] ? lbl_q[gi - 1]
                                    :                  new_lbl;
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // List entry currently being counted / scanned
    // ------------------------------------------------------------------
    logic [3:0]    cur_lbl;
    logic          cur_valid;
    logic [CW-1:0] cur_votes;

    assign cur_lbl   = lbl_q[idx_q];
    assign cur_valid = {1'b0, cur_lbl} < NL;
    assign cur_votes = cnt_q[cur_lbl];

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        dist_d      = dist_q;
        lbl_d       = lbl_q;
        cnt_d       = cnt_q;
        cand_cnt_d  = cand_cnt_q;
        idx_d       = idx_q;
        win_d       = win_q;
        best_d      = best_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;

        case (state_q)
            COLLECT: begin
                if (accept) begin
                    dist_d     = ins_dist;
                    lbl_d      = ins_lbl;
                    cand_cnt_d = cand_cnt_q + NW'(1);
                    if (cand_cnt_q == LAST_CAND) begin
                        state_d = COUNT;
                        idx_d   = '0;
                        for (int i = 0; i < 16; i++) begin
                            cnt_d[i] = '0;
                        end
                    end
                end
            end

            COUNT: begin
                if (cur_valid) begin
                    cnt_d[cur_lbl] = cur_votes + CW'(1);
                end
                if (idx_q == LAST_IDX) begin
                    state_d = SCAN;
                    idx_d   = '0;
                    win_d   = NO_LABEL;
                    best_d  = '0;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end

            SCAN: begin
                // Strictly greater: on a tie the label met first (nearest
                // member closest to list[0]) is kept.
                if (cur_valid && (cur_votes > best_q)) begin
                    win_d  = cur_lbl;
                    best_d = cur_votes;
                end
                if (idx_q == LAST_IDX) begin
                    state_d         = EMIT;
                    out_valid_d     = 1'b1;
                    out_data_d      = '0;
                    out_data_d[3:0] = win_d;
`ifdef KNN_VOTE_DIST_OUT_EN
                    out_data_d[8 +: CW]         = best_d;
                    out_data_d[16 +: DIST_BITS] = dist_q[0];
`endif
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end

            EMIT: begin
                if (axis.Output_1_V_TREADY) begin
                    state_d     = COLLECT;
                    out_valid_d = 1'b0;
                    out_data_d  = '0;
                    cand_cnt_d  = '0;
                    for (int i = 0; i < K; i++) begin
                        dist_d[i] = FAR;
                        lbl_d[i]  = NO_LABEL;
                    end
                end
            end

            default: state_d = COLLECT;
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q     <= COLLECT;
            cand_cnt_q  <= '0;
            idx_q       <= '0;
            win_q       <= NO_LABEL;
            best_q      <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            for (int i = 0; i < K; i++) begin
                dist_q[i] <= FAR;
                lbl_q[i]  <= NO_LABEL;
            end
            for (int i = 0; i < 16; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            dist_q      <= dist_d;
            lbl_q       <= lbl_d;
            cnt_q       <= cnt_d;
            cand_cnt_q  <= cand_cnt_d;
            idx_q       <= idx_d;
            win_q       <= win_d;
            best_q      <= best_d;
            // Registered ready: low throughout reset, high from the first
            // edge after release, and low in the cycle after the last
            // candidate of an image is taken.
            in_ready_q  <= (state_d == COLLECT);
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign axis.Input_1_V_TREADY  = in_ready_q;
    assign axis.Output_1_V_TVALID = out_valid_q;
    assign axis.Output_1_V_TDATA  = out_data_q;

endmodule

// File: tb/tb_knn_vote.sv
// ----------------------------------------------------------------------------
// tb_knn_vote
//   Self-checking bench for knn_vote (default parameters). Directed images
//   carry hand-derived expected words; random images are checked against a
//   reference model (stable selection of the K nearest, then majority vote).
//   Result latency, output hold under backpressure, input hold-off, and
//   asynchronous reset are checked as well.
// ----------------------------------------------------------------------------
module tb_knn_vote;
    localparam int K        = 3;
    localparam int NUM_CAND = 30;
    localparam int LAT      = 2 * K + 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    knn_vote_if bus ();

    knn_vote dut (
        .ap_clk   (clk),
        .ap_rst_n (rst_n),
        .axis     (bus)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    int          sent     = 0;
    logic [31:0] img      [NUM_CAND];
    logic [31:0] tx_q     [$];
    logic [31:0] exp_q    [$];
    int          last_acc_q [$];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // ---------------- stimulus construction ----------------
    function automatic logic [31:0] mk_word(input int d, input int l);
        logic [19:0] junk;
        junk = 20'($urandom);
        return {l[3:0], junk, d[7:0]};
    endfunction

    function automatic logic [31:0] exp_word(input int lbl, input int votes, input int d0);
        logic [31:0] w;
        w = '0;
        w[3:0] = lbl[3:0];
`ifdef KNN_VOTE_DIST_OUT_EN
        w[11:8]  = votes[3:0];
        w[23:16] = d0[7:0];
`endif
        return w;
    endfunction

    task automatic build_far(input int lo);
        for (int j = 0; j < NUM_CAND; j++)
            img[j] = mk_word(int'($urandom_range(lo, 200)), int'($urandom_range(0, 9)));
    endtask

    task automatic rand_image();
        int hi;
        int l;
        hi = ($urandom_range(0, 1) == 1) ? 200 : 15;
        for (int j = 0; j < NUM_CAND; j++) begin
            l = ($urandom_range(0, 7) == 0) ? int'($urandom_range(10, 15)) : int'($urandom_range(0, 9));
            img[j] = mk_word(int'($urandom_range(0, hi)), l);
        end
    endtask

    // Reference: pick the K smallest distances, earliest arrival first on
    // equal distance, then vote; first-listed label wins a tie.
    function automatic logic [31:0] model_result();
        bit used  [NUM_CAND];
        int pick  [K];
        int votes [16];
        int pos;
        int lbl;
        int best;
        int win;
        for (int j = 0; j < NUM_CAND; j++) used[j] = 1'b0;
        for (int j = 0; j < 16; j++) votes[j] = 0;
        for (int k = 0; k < K; k++) begin
            pos = -1;
            for (int j = 0; j < NUM_CAND; j++)
                if (!used[j] && (pos < 0 || img[j][7:0] < img[pos][7:0])) pos = j;
            used[pos] = 1'b1;
            pick[k]   = pos;
        end
        for (int k = 0; k < K; k++) begin
            lbl = int'(img[pick[k]][31:28]);
            if (lbl < 10) votes[lbl]++;
        end
        best = 0;
        win  = 15;
        for (int k = 0; k < K; k++) begin
            lbl = int'(img[pick[k]][31:28]);
            if (lbl < 10 && votes[lbl] > best) begin
                best = votes[lbl];
                win  = lbl;
            end
        end
        return exp_word(win, best, int'(img[pick[0]][7:0]));
    endfunction

    task automatic queue_image(input logic [31:0] exp);
        for (int j = 0; j < NUM_CAND; j++) tx_q.push_back(img[j]);
        exp_q.push_back(exp);
    endtask

    // ---------------- driver / monitor ----------------
    task automatic drive(input int n, input int gap_max);
        int w;
        int gap;
        for (int i = 0; i < n; i++) begin
            gap = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
            repeat (gap) begin
                bus.Input_1_V_TVALID = 1'b0;
                bus.Input_1_V_TDATA  = $urandom;
                @(posedge clk); #1;
            end
            bus.Input_1_V_TVALID = 1'b1;
            bus.Input_1_V_TDATA  = tx_q[0];
            w = 0;
            forever begin
                @(negedge clk);
                if (bus.Input_1_V_TREADY) break;
                w++;
                if (w > 400) begin
                    $display("FAIL in_ready_timeout: got TREADY=0 for %0d cycles, expected 1", w);
                    $fatal(1, "input stalled");
                end
            end
            sent++;
            if (sent % NUM_CAND == 0) last_acc_q.push_back(cyc + 1);
            void'(tx_q.pop_front());
            @(posedge clk); #1;
        end
        bus.Input_1_V_TVALID = 1'b0;
    endtask

    task automatic collect(input int n, input int max_bp);
        int          w;
        int          hold;
        int          t_acc;
        logic [31:0] exp;
        logic [31:0] held;
        for (int r = 0; r < n; r++) begin
            bus.Output_1_V_TREADY = (max_bp == 0);
            w = 0;
            forever begin
                @(negedge clk);
                if (bus.Output_1_V_TVALID) break;
                w++;
                if (w > 600) begin
                    $display("FAIL out_valid_timeout: got TVALID=0 for %0d cycles, expected 1", w);
                    $fatal(1, "no result");
                end
            end
            exp   = exp_q.pop_front();
            t_acc = last_acc_q.pop_front();
            check_val("latency", 32'(cyc + 1 - t_acc), 32'(LAT));
            check_val("result", bus.Output_1_V_TDATA, exp);
            if (max_bp > 0) begin
                held = bus.Output_1_V_TDATA;
                hold = int'($urandom_range(1, max_bp));
                repeat (hold) begin
                    @(negedge clk);
                    check_val("hold_valid", 32'(bus.Output_1_V_TVALID), 32'd1);
                    check_val("hold_data", bus.Output_1_V_TDATA, held);
                    check_val("hold_in_ready", 32'(bus.Input_1_V_TREADY), 32'd0);
                end
                bus.Output_1_V_TREADY = 1'b1;
            end
            @(posedge clk); #1;
            check_val("valid_after_hs", 32'(bus.Output_1_V_TVALID), 32'd0);
            check_val("ready_after_hs", 32'(bus.Input_1_V_TREADY), 32'd1);
        end
        bus.Output_1_V_TREADY = 1'b1;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        #1;
        check_val("rst_out_valid", 32'(bus.Output_1_V_TVALID), 32'd0);
        check_val("rst_out_data", bus.Output_1_V_TDATA, 32'd0);
        check_val("rst_in_ready", 32'(bus.Input_1_V_TREADY), 32'd0);
        bus.Input_1_V_TVALID  = 1'b0;
        bus.Output_1_V_TREADY = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check_val("rel_in_ready_low", 32'(bus.Input_1_V_TREADY), 32'd0);
        @(posedge clk); #1;
        check_val("rel_in_ready_high", 32'(bus.Input_1_V_TREADY), 32'd1);
        sent = 0;
        tx_q.delete();
        exp_q.delete();
        last_acc_q.delete();
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int w;
        bus.Input_1_V_TDATA   = '0;
        bus.Input_1_V_TVALID  = 1'b0;
        bus.Output_1_V_TREADY = 1'b0;
        #2;
        pulse_reset();

        // T1 majority: (5,L7) (9,L7) (12,L2), all others >= 40
        build_far(40);
        img[20] = mk_word(5, 7);
        img[4]  = mk_word(9, 7);
        img[11] = mk_word(12, 2);
        queue_image(exp_word(7, 2, 5));
        fork drive(NUM_CAND, 0); collect(1, 0); join

        // T2 three-way tie: nearest (4,L3) arrives last
        build_far(40);
        img[29] = mk_word(4, 3);
        img[0]  = mk_word(6, 8);
        img[15] = mk_word(7, 1);
        queue_image(exp_word(3, 1, 4));
        fork drive(NUM_CAND, 0); collect(1, 0); join

        // T3 equal distances keep arrival order: list L2,L6,L6
        for (int j = 0; j < NUM_CAND; j++) img[j] = mk_word(200, int'($urandom_range(0, 15)));
        img[0] = mk_word(5, 2);
        img[1] = mk_word(5, 6);
        img[2] = mk_word(5, 6);
        img[3] = mk_word(5, 9);
        queue_image(exp_word(6, 2, 5));
        fork drive(NUM_CAND, 2); collect(1, 0); join

        // T4 backpressure with the next image already waiting
        for (int i = 0; i < 2; i++) begin
            rand_image();
            queue_image(model_result());
        end
        fork drive(2 * NUM_CAND, 0); collect(2, 5); join

        // T5a reset after 12 candidates, then a clean image
        rand_image();
        queue_image(model_result());
        drive(12, 0);
        pulse_reset();
        rand_image();
        queue_image(model_result());
        fork drive(NUM_CAND, 0); collect(1, 0); join

        // T5b reset while a result is pending
        rand_image();
        queue_image(model_result());
        bus.Output_1_V_TREADY = 1'b0;
        drive(NUM_CAND, 0);
        w = 0;
        while (!bus.Output_1_V_TVALID && w < 100) begin
            @(negedge clk);
            w++;
        end
        check_val("emit_reached", 32'(bus.Output_1_V_TVALID), 32'd1);
        @(posedge clk); #1;
        pulse_reset();
        rand_image();
        queue_image(model_result());
        fork drive(NUM_CAND, 0); collect(1, 0); join

        // T6 back-to-back images, TVALID and TREADY always high
        for (int i = 0; i < 3; i++) begin
            rand_image();
            queue_image(model_result());
        end
        fork drive(3 * NUM_CAND, 0); collect(3, 0); join

        // Random gaps and random backpressure
        for (int i = 0; i < 6; i++) begin
            rand_image();
            queue_image(model_result());
        end
        fork drive(6 * NUM_CAND, 3); collect(6, 4); join

        check_val("tx_drained", 32'(tx_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got no end of test by cycle %0d, expected completion", cyc);
        $fatal(1, "watchdog");
    end
endmodule
